// File: rtl/lsu_pkg.sv
// rtl/lsu_pkg.sv - shared encodings for the load/store unit
//
// Holds the RV32I funct3 width/sign encodings, the FSM state enum,
// the default data-memory depth and a funct3 legality helper.
package lsu_pkg;

  localparam int unsigned LSU_MEM_DEPTH = 256;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [1:0] {IDLE, RD, WR, RSP} lsu_state_e;

  // Unsigned variants only exist for loads; 011/110/111 are never legal.
  function automatic logic f3_illegal(input logic we, input logic [2:0] f3);
    case (f3)
      F3_B, F3_H, F3_W: return 1'b0;
      F3_BU, F3_HU:     return we;
      default:          return 1'b1;
    endcase
  endfunction

endpackage

// File: rtl/lsu_align.sv
// rtl/lsu_align.sv - lane extraction/extension and store merge
//
// Purely combinational.
// Ports:
//   funct3     access width/sign
//   offset     byte offset in word, already aligned to the access size
//   word       memory word (read data)
//   wdata      right-aligned store data
//   load_data  selected lane, sign- or zero-extended
//   store_word word with the addressed lanes replaced by wdata
module lsu_align
  import lsu_pkg::*;
(
  input  logic [2:0]  funct3,
  input  logic [1:0]  offset,
  input  logic [31:0] word,
  input  logic [31:0] wdata,
  output logic [31:0] load_data,
  output logic [31:0] store_word
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    byte_sel = word[{offset, 3'b000} +: 8];
    half_sel = offset[1] ? word[31:16] : word[15:0];

    load_data = word;
    case (funct3)
      F3_B:    load_data = {{24{byte_sel[7]}}, byte_sel};
      F3_H:    load_data = {{16{half_sel[15]}}, half_sel};
      F3_BU:   load_data = {24'b0, byte_sel};
      F3_HU:   load_data = {16'b0, half_sel};
      default: load_data = word;
    endcase

    store_word = word;
    case (funct3)
      F3_B: store_word[{offset, 3'b000} +: 8] = wdata[7:0];
      F3_H: begin
        if (offset[1]) store_word[31:16] = wdata[15:0];
        else           store_word[15:0]  = wdata[15:0];
      end
      default: store_word = wdata;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// rtl/load_store_unit.sv - RV32I load/store unit with read-modify-write sub-word stores
//
// Optional feature macro: LSU_MISALIGN_TRAP_EN (misaligned H/W accesses
// return rsp_err instead of having their low address bits cleared).
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   req_valid/ready     request handshake (ready only in IDLE)
//   req_we/funct3       store flag and RV32I width/sign
//   req_addr/wdata      byte address, right-aligned store data
//   rsp_valid/rdata/err one-cycle completion pulse with load data / error
//   mem_addr            word index, wrapped to MEM_DEPTH
//   mem_rd_en/wr_en     data-memory strobes (mutually exclusive)
//   mem_wr_data         full word to write
//   mem_rd_data         memory word, valid combinationally with mem_rd_en
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int unsigned MEM_DEPTH = LSU_MEM_DEPTH
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err,
  output logic [31:0] mem_addr,
  output logic        mem_rd_en,
  output logic        mem_wr_en,
  output logic [31:0] mem_wr_data,
  input  logic [31:0] mem_rd_data
);

  localparam int unsigned AW = $clog2(MEM_DEPTH);

  lsu_state_e state, state_nxt;

  logic          we_q;
  logic [2:0]    f3_q;
  logic [AW-1:0] idx_q;
  logic [1:0]    off_q;
  logic [31:0]   wdata_q;
  logic          err_q;
  logic [31:0]   rd_word_q;

  logic          accept;
  logic [1:0]    off_in;
  logic          err_in;
  logic [31:0]   load_data;
  logic [31:0]   store_word;

  assign accept = req_valid && req_ready;

  // Lane offset rounded down to the access size; misalignment either
  // traps or is silently cleared depending on the build.
  always_comb begin
    off_in = req_addr[1:0];
    err_in = f3_illegal(req_we, req_funct3);
    case (req_funct3[1:0])
      2'b01: begin
        off_in[0] = 1'b0;
`ifdef LSU_MISALIGN_TRAP_EN
        if (req_addr[0]) err_in = 1'b1;
`endif
      end
      2'b10: begin
        off_in = 2'b00;
`ifdef LSU_MISALIGN_TRAP_EN
        if (req_addr[1:0] != 2'b00) err_in = 1'b1;
`endif
      end
      default: ;
    endcase
  end

  lsu_align u_align (
    .funct3     (f3_q),
    .offset     (off_q),
    .word       (rd_word_q),
    .wdata      (wdata_q),
    .load_data  (load_data),
    .store_word (store_word)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      we_q      <= 1'b0;
      f3_q      <= 3'b000;
      idx_q     <= '0;
      off_q     <= 2'b00;
      wdata_q   <= 32'b0;
      err_q     <= 1'b0;
      rd_word_q <= 32'b0;
    end else begin
      state <= state_nxt;
      if (accept) begin
        we_q    <= req_we;
        f3_q    <= req_funct3;
        idx_q   <= req_addr[AW+1:2];
        off_q   <= off_in;
        wdata_q <= req_wdata;
        err_q   <= err_in;
      end
      if (state == RD) rd_word_q <= mem_rd_data;
    end
  end

  // Outputs are gated by rst so they read zero for the whole reset
  // window, including the cycle in which reset is first sampled.
  always_comb begin
    state_nxt   = state;
    req_ready   = 1'b0;
    rsp_valid   = 1'b0;
    rsp_err     = 1'b0;
    rsp_rdata   = 32'b0;
    mem_addr    = 32'b0;
    mem_rd_en   = 1'b0;
    mem_wr_en   = 1'b0;
    mem_wr_data = 32'b0;
    if (!rst) begin
      case (state)
        IDLE: begin
          req_ready = 1'b1;
          if (req_valid) begin
            if (err_in)                                state_nxt = RSP;
            else if (req_we && req_funct3 == F3_W)     state_nxt = WR;
            else                                       state_nxt = RD;
          end
        end
        RD: begin
          mem_rd_en = 1'b1;
          mem_addr  = {{(32-AW){1'b0}}, idx_q};
          state_nxt = we_q ? WR : RSP;
        end
        WR: begin
          mem_wr_en   = 1'b1;
          mem_addr    = {{(32-AW){1'b0}}, idx_q};
          mem_wr_data = store_word;
          state_nxt   = RSP;
        end
        RSP: begin
          rsp_valid = 1'b1;
          rsp_err   = err_q;
          rsp_rdata = (we_q || err_q) ? 32'b0 : load_data;
          state_nxt = IDLE;
        end
        default: state_nxt = IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_load_store_unit.sv
// tb/tb_load_store_unit.sv - scoreboard bench for load_store_unit
module tb_load_store_unit;

  localparam int DEPTH = 256;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_we = 1'b0;
  logic [2:0]  req_funct3 = 3'b0;
  logic [31:0] req_addr = 32'b0;
  logic [31:0] req_wdata = 32'b0;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
  logic [31:0] mem_addr;
  logic        mem_rd_en;
  logic        mem_wr_en;
  logic [31:0] mem_wr_data;
  logic [31:0] mem_rd_data;

  always #5 clk = ~clk;

  load_store_unit #(.MEM_DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .mem_addr(mem_addr), .mem_rd_en(mem_rd_en), .mem_wr_en(mem_wr_en),
    .mem_wr_data(mem_wr_data), .mem_rd_data(mem_rd_data)
  );

  logic [31:0] mem     [DEPTH];
  logic [31:0] ref_mem [DEPTH];
  logic        load_mem = 1'b1;

  always_comb mem_rd_data = mem_rd_en ? mem[mem_addr[7:0]] : 32'hDEAD_BEEF;

  always @(posedge clk) begin
    if (load_mem) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= ref_mem[i];
    end else if (mem_wr_en) begin
      mem[mem_addr[7:0]] <= mem_wr_data;
    end
  end

  typedef struct {
    int unsigned acc;
    int unsigned lat;
    logic        err;
    logic [31:0] rdata;
  } rsp_t;

  typedef struct {
    logic [31:0] idx;
    logic [31:0] data;
  } wr_t;

  rsp_t        rsp_q[$];
  wr_t         wr_q[$];
  int          tests = 0;
  int          fails = 0;
  int unsigned cyc = 0;
  logic        cur_err = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference model: RV32I semantics over a word array.
  task automatic model(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                       input logic [31:0] wd, output logic err, output logic [31:0] rdata,
                       output int unsigned lat, output logic do_wr, output logic [31:0] idx,
                       output logic [31:0] wword);
    int          size;
    int          pos;
    logic [31:0] w;
    logic [31:0] mask;
    idx   = (addr / 4) % DEPTH;
    w     = ref_mem[idx];
    err   = 1'b0;
    do_wr = 1'b0;
    rdata = 32'b0;
    wword = w;
    lat   = 1;
    case (f3)
      3'd0, 3'd4: size = 1;
      3'd1, 3'd5: size = 2;
      3'd2:       size = 4;
      default: begin size = 0; err = 1'b1; end
    endcase
    if (we && f3 > 3'd2) err = 1'b1;
`ifdef LSU_MISALIGN_TRAP_EN
    if (size > 1 && (addr % size) != 0) err = 1'b1;
`endif
    if (!err) begin
      pos  = int'(addr % 4) - int'(addr % 4) % size;
      mask = (size == 4) ? 32'hFFFF_FFFF : (32'd1 << (8 * size)) - 32'd1;
      if (!we) begin
        rdata = (w >> (8 * pos)) & mask;
        if (f3 < 3'd4 && size < 4 && rdata[8*size-1]) rdata = rdata | ~mask;
        lat = 2;
      end else begin
        wword = (w & ~(mask << (8 * pos))) | ((wd & mask) << (8 * pos));
        do_wr = 1'b1;
        lat   = (size == 4) ? 2 : 3;
        ref_mem[idx] = wword;
      end
    end
  endtask

  task automatic wait_ready();
    int n = 0;
    @(negedge clk);
    while (!req_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (!req_ready) check("ready_timeout", {31'b0, req_ready}, 32'd1);
  endtask

  task automatic issue(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                       input logic [31:0] wd);
    rsp_t        e;
    wr_t         wexp;
    logic        err, dw;
    logic [31:0] rd, idx, ww;
    int unsigned lat;
    int          n;
    wait_ready();
    model(we, f3, addr, wd, err, rd, lat, dw, idx, ww);
    e.acc = cyc; e.lat = lat; e.err = err; e.rdata = rd;
    rsp_q.push_back(e);
    if (dw) begin
      wexp.idx = idx; wexp.data = ww;
      wr_q.push_back(wexp);
    end
    cur_err    = err;
    req_valid  = 1'b1;
    req_we     = we;
    req_funct3 = f3;
    req_addr   = addr;
    req_wdata  = wd;
    @(posedge clk);
    #1;
    req_valid  = 1'b0;
    req_we     = ~we;
    req_funct3 = 3'($urandom);
    req_addr   = $urandom;
    req_wdata  = $urandom;
    n = 0;
    while (rsp_q.size() != 0 && n < 10) begin
      @(negedge clk);
      n++;
    end
    if (rsp_q.size() != 0) begin
      check("rsp_timeout", rsp_q.size(), 32'd0);
      rsp_q.delete();
    end
    cur_err = 1'b0;
  endtask

  // Response / memory-write monitor.
  always @(negedge clk) begin : mon
    rsp_t e;
    wr_t  w;
    if (rsp_valid) begin
      if (rsp_q.size() == 0) begin
        check("unexpected_rsp", {31'b0, rsp_valid}, 32'd0);
      end else begin
        e = rsp_q.pop_front();
        check("rsp_err", {31'b0, rsp_err}, {31'b0, e.err});
        check("rsp_rdata", rsp_rdata, e.rdata);
        check("rsp_latency", cyc - e.acc, e.lat);
      end
    end
    if (mem_wr_en) begin
      if (wr_q.size() == 0) begin
        check("unexpected_write", {31'b0, mem_wr_en}, 32'd0);
      end else begin
        w = wr_q.pop_front();
        check("wr_addr", mem_addr, w.idx);
        check("wr_data", mem_wr_data, w.data);
      end
    end
    if (mem_rd_en || mem_wr_en) begin
      check("strobe_overlap", {31'b0, mem_rd_en & mem_wr_en}, 32'd0);
      if (cur_err) check("strobe_on_error", {30'b0, mem_rd_en, mem_wr_en}, 32'd0);
    end
  end

  initial begin
    int bad;
    for (int i = 0; i < DEPTH; i++) ref_mem[i] = $urandom;
    ref_mem[5] = 32'h8070_60F0;

    rst = 1'b1;
    load_mem = 1'b1;
    repeat (3) @(negedge clk);
    check("reset_ctrl", {27'b0, req_ready, rsp_valid, rsp_err, mem_rd_en, mem_wr_en}, 32'd0);
    check("reset_rdata", rsp_rdata, 32'd0);
    check("reset_addr", mem_addr, 32'd0);
    check("reset_wdata", mem_wr_data, 32'd0);
    load_mem = 1'b0;
    rst = 1'b0;
    @(negedge clk);
    check("ready_after_reset", {31'b0, req_ready}, 32'd1);

    // Directed cases around word 5 = 0x8070_60F0.
    issue(1'b0, 3'b000, 32'h14, 32'h0);       // LB  -> FFFF_FFF0
    issue(1'b0, 3'b101, 32'h16, 32'h0);       // LHU -> 0000_8070
    issue(1'b1, 3'b000, 32'h15, 32'hAB);      // SB  -> 8070_ABF0
    issue(1'b0, 3'b010, 32'h14, 32'h0);       // LW readback
    issue(1'b0, 3'b010, 32'h06, 32'h0);       // misaligned LW
    issue(1'b1, 3'b110, 32'h20, 32'h1234);    // illegal store funct3
    issue(1'b1, 3'b101, 32'h20, 32'h1234);    // unsigned store is illegal
    issue(1'b0, 3'b011, 32'h20, 32'h0);       // illegal load funct3
    issue(1'b1, 3'b010, 32'hFFFF_FFFC, 32'hCAFE_F00D);  // wraps to word 255
    issue(1'b0, 3'b010, 32'h0000_03FC, 32'h0);          // same word via wrap
    issue(1'b1, 3'b001, 32'h0000_0402, 32'hBEEF);       // SH upper lane, word 0
    issue(1'b0, 3'b001, 32'h0000_0002, 32'h0);          // LH sign-extended
    issue(1'b1, 3'b001, 32'h0000_0013, 32'h7777);       // misaligned SH

    for (int k = 0; k < 300; k++) begin
      issue(1'($urandom), 3'($urandom_range(0, 7)), $urandom, $urandom);
    end

    // Reset while an SH is in its read cycle: nothing may follow.
    wait_ready();
    cur_err    = 1'b0;
    req_valid  = 1'b1;
    req_we     = 1'b1;
    req_funct3 = 3'b001;
    req_addr   = 32'h40;
    req_wdata  = 32'h5555;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    @(negedge clk);
    check("sh_in_rd", {31'b0, mem_rd_en}, 32'd1);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("ready_after_abort", {31'b0, req_ready}, 32'd1);
    repeat (4) @(negedge clk);

    issue(1'b0, 3'b010, 32'h40, 32'h0);       // word untouched by aborted SH

    repeat (2) @(negedge clk);
    bad = 0;
    for (int i = 0; i < DEPTH; i++) if (mem[i] !== ref_mem[i]) bad++;
    check("mem_image", bad, 32'd0);
    check("rsp_queue_drained", rsp_q.size(), 32'd0);
    check("wr_queue_drained", wr_q.size(), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
